// File: rtl/seg7_scan_ctrl_if.sv
// Write-port bundle for seg7_scan_ctrl: one addressed digit update per strobe.
interface seg7_scan_ctrl_if #(
  parameter int AW = 2
) ();
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_dp;

  modport master (output wr_en, wr_addr, wr_data, wr_dp);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_dp);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment controller: per-digit hex/dp
// storage, refresh scan with one-cycle anti-ghost blank and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_ctrl_if.slave     wr,
  input  logic [N_DIGITS-1:0] digit_en,
  input  logic                lz_en,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic [N_DIGITS-1:0] an
);
  localparam int AW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [AW-1:0] SIDX_MAX = AW'(N_DIGITS - 1);

  logic [3:0]          r_val [N_DIGITS];
  logic [N_DIGITS-1:0] r_dp;
  logic [PW-1:0]       r_pcnt;
  logic [AW-1:0]       r_sidx;
  logic [6:0]          r_seg;
  logic                r_dp_n;
  logic [N_DIGITS-1:0] r_an;

  logic                w_hi_zero;
  logic                w_dark;
  logic [3:0]          w_cur;
  logic [6:0]          w_pat;
  logic [N_DIGITS-1:0] w_an;

  // Suppression only needs evaluating for the digit currently scanned.
  always_comb begin
    w_hi_zero = 1'b1;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if ((j >= 32'(r_sidx)) && (r_val[j] != 4'h0)) w_hi_zero = 1'b0;
    end
    w_dark = !digit_en[r_sidx]
           || (lz_en && (r_sidx != '0) && w_hi_zero)
           || (r_pcnt == '0);
    w_cur  = r_val[r_sidx];
    w_an   = '1;
    w_an[r_sidx] = 1'b0;
  end

  always_comb begin
    w_pat = 7'b1111111;
    case (w_cur)
      4'h0: w_pat = 7'b0000001;
      4'h1: w_pat = 7'b1001111;
      4'h2: w_pat = 7'b0010010;
      4'h3: w_pat = 7'b0000110;
      4'h4: w_pat = 7'b1001100;
      4'h5: w_pat = 7'b0100100;
      4'h6: w_pat = 7'b0100000;
      4'h7: w_pat = 7'b0001111;
      4'h8: w_pat = 7'b0000000;
      4'h9: w_pat = 7'b0000100;
      4'hA: w_pat = 7'b0001000;
      4'hB: w_pat = 7'b1100000;
      4'hC: w_pat = 7'b0110001;
      4'hD: w_pat = 7'b1000010;
      4'hE: w_pat = 7'b0110000;
      4'hF: w_pat = 7'b0111000;
      default: w_pat = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_DIGITS; i++) r_val[i] <= '0;
      r_dp   <= '0;
      r_pcnt <= '0;
      r_sidx <= '0;
      r_an   <= '1;
      r_seg  <= '1;
      r_dp_n <= 1'b1;
    end else begin
      if (wr.wr_en && (32'(wr.wr_addr) < N_DIGITS)) begin
        r_val[wr.wr_addr] <= wr.wr_data;
        r_dp[wr.wr_addr]  <= wr.wr_dp;
      end

      if (r_pcnt == PCNT_MAX) begin
        r_pcnt <= '0;
        r_sidx <= (r_sidx == SIDX_MAX) ? '0 : r_sidx + 1'b1;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end

      if (w_dark) begin
        r_an   <= '1;
        r_seg  <= '1;
        r_dp_n <= 1'b1;
      end else begin
        r_an   <= w_an;
        r_seg  <= w_pat;
        r_dp_n <= ~r_dp[r_sidx];
      end
    end
  end

  assign seg  = r_seg;
  assign dp_n = r_dp_n;
  assign an   = r_an;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based reference model queues the
// expected pins per edge; a negedge monitor pops and compares.
module tb_seg7_scan_ctrl;
  localparam int ND = 5;
  localparam int RD = 4;
  localparam int AW = 3;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp_n;
  } out_t;

  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] digit_en;
  logic          lz_en;
  logic [6:0]    seg;
  logic          dp_n;
  logic [ND-1:0] an;

  seg7_scan_ctrl_if #(.AW(AW)) u_if ();

  seg7_scan_ctrl #(.N_DIGITS(ND), .REFRESH_DIV(RD)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (u_if),
    .digit_en (digit_en),
    .lz_en    (lz_en),
    .seg      (seg),
    .dp_n     (dp_n),
    .an       (an)
  );

  always #5 clk = ~clk;

  int   m_val [ND];
  bit   m_dp  [ND];
  int   m_t;
  out_t q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: slot position is a pure function of cycles since reset release.
  always @(posedge clk) begin
    out_t e;
    int   pc;
    int   sx;
    bit   hz;
    e.an   = '1;
    e.seg  = '1;
    e.dp_n = 1'b1;
    if (rst) begin
      m_t = 0;
      for (int j = 0; j < ND; j++) begin
        m_val[j] = 0;
        m_dp[j]  = 1'b0;
      end
    end else begin
      pc = m_t % RD;
      sx = (m_t / RD) % ND;
      hz = 1'b1;
      for (int j = sx; j < ND; j++) if (m_val[j] != 0) hz = 1'b0;
      if (digit_en[sx] && !(lz_en && sx != 0 && hz) && pc != 0) begin
        e.an   = ~(ND'(1) << sx);
        e.seg  = HEX[m_val[sx]];
        e.dp_n = !m_dp[sx];
      end
      m_t++;
      if (u_if.wr_en && (int'(u_if.wr_addr) < ND)) begin
        m_val[u_if.wr_addr] = int'(u_if.wr_data);
        m_dp[u_if.wr_addr]  = u_if.wr_dp;
      end
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    out_t e;
    out_t a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a.an   = an;
      a.seg  = seg;
      a.dp_n = dp_n;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL pins @%0t: got an=%b seg=%b dp_n=%b, want an=%b seg=%b dp_n=%b",
                 $time, a.an, a.seg, a.dp_n, e.an, e.seg, e.dp_n);
      end
    end
  end

  task automatic chk(input string nm, input logic [ND+7:0] got, input logic [ND+7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int d, input bit p);
    @(negedge clk);
    u_if.wr_en   = 1'b1;
    u_if.wr_addr = AW'(a);
    u_if.wr_data = 4'(d);
    u_if.wr_dp   = p;
    @(negedge clk);
    u_if.wr_en   = 1'b0;
  endtask

  initial begin
    bit found;
    rst          = 1'b0;
    digit_en     = '1;
    lz_en        = 1'b0;
    u_if.wr_en   = 1'b0;
    u_if.wr_addr = '0;
    u_if.wr_data = '0;
    u_if.wr_dp   = 1'b0;

    #2 rst = 1'b1;
    #1 chk("reset_async", {an, seg, dp_n}, {{ND{1'b1}}, 7'b1111111, 1'b1});
    idle(3);
    rst = 1'b0;
    idle(2 * ND * RD);

    for (int i = 0; i < ND; i++) wr(i, i + 1, 1'b0);
    idle(2 * ND * RD);

    for (int v = 0; v < 16; v++) begin
      wr(0, v, v[0]);
      idle(ND * RD);
    end

    lz_en = 1'b1;
    wr(4, 0, 1'b0); wr(3, 0, 1'b1); wr(2, 0, 1'b0); wr(1, 7, 1'b0); wr(0, 0, 1'b0);
    idle(2 * ND * RD);
    wr(1, 0, 1'b0);
    idle(2 * ND * RD);
    lz_en = 1'b0;
    idle(ND * RD);

    for (int a = ND; a < (1 << AW); a++) wr(a, $urandom_range(1, 15), 1'b1);
    idle(ND * RD);

    for (int i = 0; i < ND; i++) wr(i, $urandom_range(1, 15), 1'($urandom_range(0, 1)));
    digit_en = 5'b10101; idle(2 * ND * RD);
    digit_en = 5'b01010; idle(2 * ND * RD);
    digit_en = '0;       idle(ND * RD);
    digit_en = '1;

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      u_if.wr_en   = 1'($urandom_range(0, 1));
      u_if.wr_addr = AW'($urandom_range(0, (1 << AW) - 1));
      u_if.wr_data = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      u_if.wr_dp   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) digit_en = ND'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
    end
    @(negedge clk);
    u_if.wr_en = 1'b0;
    digit_en   = '1;
    lz_en      = 1'b0;

    wr(2, 9, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 4 * ND * RD && !found; k++) begin
      @(negedge clk);
      if ((m_t % RD) == 2 && ((m_t / RD) % ND) == 2) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL midslot_wait: got timeout want digit2 slot");
    end
    chk("midslot_lit", {an, seg, dp_n}, {5'b11011, HEX[9], 1'b0});
    #2 rst = 1'b1;
    #1 chk("reset_midslot", {an, seg, dp_n}, {{ND{1'b1}}, 7'b1111111, 1'b1});
    idle(2);
    rst = 1'b0;
    idle(2 * ND * RD + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
